// File: rtl/uart_tx_pkg.sv
// Shared types and encodings for the UART TX frame sequencer.
// Mux_Sel codes match the downstream 4:1 line mux input order.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity of a payload; zero latency, no flow control.
// The parent registers the result on frame accept.
module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame sequencer: start, LSB-first data, optional parity, stop; start bit one cycle after accept.
// New payload is taken only in IDLE or STOP (back-to-back frames); Data_Valid elsewhere is dropped.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            Mux_Sel,
  output logic                  Ser_Data,
  output logic                  Par_Bit,
  output logic                  Busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q;
  tx_state_e             state_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  par_calc;
  logic                  accept;
  logic                  last_bit;

  assign accept   = Data_Valid && ((state_q == ST_IDLE) || (state_q == ST_STOP));
  assign last_bit = (cnt_q == LAST_BIT);

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data   (P_DATA),
    .par_typ(PAR_TYP),
    .par_bit(par_calc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_STOP: state_d = accept ? ST_START : ST_IDLE;
      ST_START:         state_d = ST_DATA;
      ST_DATA:          if (last_bit) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY:        state_d = ST_STOP;
      default:          state_d = ST_IDLE;
    endcase
  end

  // The final data bit is not shifted out so Ser_Data keeps the MSB while idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        shift_q   <= P_DATA;
        par_en_q  <= PAR_EN;
        par_bit_q <= par_calc;
        cnt_q     <= '0;
      end else if (state_q == ST_DATA) begin
        if (last_bit) begin
          cnt_q <= '0;
        end else begin
          cnt_q   <= cnt_q + CNT_W'(1);
          shift_q <= shift_q >> 1;
        end
      end
    end
  end

  // Mux_Sel decodes the state register only, so reset forces the line idle-high at once.
  always_comb begin
    Mux_Sel = MUX_STOP;
    case (state_q)
      ST_START:  Mux_Sel = MUX_START;
      ST_DATA:   Mux_Sel = MUX_DATA;
      ST_PARITY: Mux_Sel = MUX_PAR;
      default:   Mux_Sel = MUX_STOP;
    endcase
  end

  assign Busy     = (state_q != ST_IDLE);
  assign Ser_Data = shift_q[0];
  assign Par_Bit  = par_bit_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: per-cycle schedule model plus directed literal frames and random traffic.
module tb_uart_tx_frame_ctrl;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [1:0]    Mux_Sel;
  logic          Ser_Data;
  logic          Par_Bit;
  logic          Busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Mux_Sel   (Mux_Sel),
    .Ser_Data  (Ser_Data),
    .Par_Bit   (Par_Bit),
    .Busy      (Busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted frame expands into a list of expected line cycles.
  typedef struct packed {
    logic [1:0] mux;
    logic       busy;
    logic       ser_vld;
    logic       ser;
  } exp_t;

  exp_t sched[$];
  logic m_par;
  logic m_acc;

  function automatic exp_t mk(input logic [1:0] mux, input logic sv, input logic s);
    exp_t e;
    e.mux = mux; e.busy = 1'b1; e.ser_vld = sv; e.ser = s;
    return e;
  endfunction

  function automatic logic ref_parity(input logic [DW-1:0] d, input logic odd);
    int ones;
    ones = 0;
    for (int i = 0; i < DW; i++) ones += int'(d[i]);
    return 1'(ones % 2) ^ odd;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      sched.delete();
      m_par = 1'b0;
    end else begin
      // A new frame is taken when idle or in the final (stop) cycle of a frame.
      m_acc = Data_Valid && (sched.size() <= 1);
      if (sched.size() > 0) void'(sched.pop_front());
      if (m_acc) begin
        sched.push_back(mk(2'b00, 1'b1, P_DATA[0]));
        for (int i = 0; i < DW; i++) sched.push_back(mk(2'b10, 1'b1, P_DATA[i]));
        if (PAR_EN) sched.push_back(mk(2'b11, 1'b0, 1'b0));
        sched.push_back(mk(2'b01, 1'b0, 1'b0));
        m_par = ref_parity(P_DATA, PAR_TYP);
      end
    end
  end

  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (sched.size() == 0) begin
        check("idle_mux", 64'(Mux_Sel), 64'(2'b01));
        check("idle_busy", 64'(Busy), 64'(1'b0));
      end else begin
        check("mux", 64'(Mux_Sel), 64'(sched[0].mux));
        check("busy", 64'(Busy), 64'(sched[0].busy));
        if (sched[0].ser_vld) check("ser", 64'(Ser_Data), 64'(sched[0].ser));
      end
      check("par", 64'(Par_Bit), 64'(m_par));
    end
  end

  logic [1:0] cap_mux  [0:31];
  logic       cap_ser  [0:31];
  logic       cap_busy [0:31];
  logic       cap_par  [0:31];

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      cap_mux[i] = Mux_Sel; cap_ser[i] = Ser_Data; cap_busy[i] = Busy; cap_par[i] = Par_Bit;
    end
  endtask

  function automatic logic [63:0] mux_vec(input int first, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = first; i < first + n; i++) v = {v[61:0], cap_mux[i]};
    return v;
  endfunction

  function automatic logic [63:0] ser_vec(input int first, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = first; i < first + n; i++) v = {v[62:0], cap_ser[i]};
    return v;
  endfunction

  function automatic int busy_count(input int first, input int n);
    int c;
    c = 0;
    for (int i = first; i < first + n; i++) c += (cap_busy[i] === 1'b1) ? 1 : 0;
    return c;
  endfunction

  task automatic drive(input logic dv, input logic [DW-1:0] d, input logic pe, input logic pt);
    Data_Valid = dv; P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
  endtask

  task automatic pulse(input logic [DW-1:0] d, input logic pe, input logic pt);
    @(posedge CLK); #2; drive(1'b1, d, pe, pt);
    @(posedge CLK); #2; Data_Valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("rst_mux", 64'(Mux_Sel), 64'(2'b01));
    check("rst_busy", 64'(Busy), 64'(1'b0));
    check("rst_ser", 64'(Ser_Data), 64'(1'b0));
    check("rst_par", 64'(Par_Bit), 64'(1'b0));
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    repeat (2) @(posedge CLK);

    // 0xA5 even parity
    pulse(8'hA5, 1'b1, 1'b0);
    capture(13);
    check("a5e_mux", mux_vec(0, 12), 64'({2'b00, {8{2'b10}}, 2'b11, 2'b01, 2'b01}));
    check("a5e_ser", ser_vec(1, 8), 64'(8'b10100101));
    check("a5e_par", 64'(cap_par[1]), 64'(1'b0));
    check("a5e_busy", 64'(busy_count(0, 13)), 64'(11));

    // 0xA5 odd parity
    pulse(8'hA5, 1'b1, 1'b1);
    capture(13);
    check("a5o_mux", mux_vec(0, 12), 64'({2'b00, {8{2'b10}}, 2'b11, 2'b01, 2'b01}));
    check("a5o_ser", ser_vec(1, 8), 64'(8'b10100101));
    check("a5o_par", 64'(cap_par[1]), 64'(1'b1));
    check("a5o_busy", 64'(busy_count(0, 13)), 64'(11));

    // 0x01 without parity
    pulse(8'h01, 1'b0, 1'b0);
    capture(11);
    check("01_mux", mux_vec(0, 11), 64'({2'b00, {8{2'b10}}, 2'b01, 2'b01}));
    check("01_ser", ser_vec(1, 8), 64'(8'b10000000));
    check("01_par", 64'(cap_par[1]), 64'(1'b1));
    check("01_busy", 64'(busy_count(0, 11)), 64'(10));

    // Back-to-back: Data_Valid held, second payload presented during STOP
    @(posedge CLK); #2; drive(1'b1, 8'h3C, 1'b1, 1'b0);
    @(posedge CLK);
    fork
      capture(24);
      begin
        repeat (10) @(posedge CLK);
        #2 P_DATA = 8'hC3;
        @(posedge CLK);
        #2 Data_Valid = 1'b0;
      end
    join
    check("b2b_mux1", mux_vec(0, 12), 64'({2'b00, {8{2'b10}}, 2'b11, 2'b01, 2'b00}));
    check("b2b_mux2", mux_vec(10, 13), 64'({2'b01, 2'b00, {8{2'b10}}, 2'b11, 2'b01, 2'b01}));
    check("b2b_ser1", ser_vec(1, 8), 64'(8'b00111100));
    check("b2b_ser2", ser_vec(12, 8), 64'(8'b11000011));
    check("b2b_par1", 64'(cap_par[5]), 64'(1'b0));
    check("b2b_par2", 64'(cap_par[15]), 64'(1'b0));
    check("b2b_busy", 64'(busy_count(0, 24)), 64'(22));

    // Data_Valid during DATA is ignored
    pulse(8'h00, 1'b0, 1'b0);
    fork
      capture(12);
      begin
        repeat (3) @(posedge CLK);
        #2 drive(1'b1, 8'hFF, 1'b1, 1'b1);
        @(posedge CLK);
        #2 drive(1'b0, 8'h00, 1'b0, 1'b0);
      end
    join
    check("ign_mux", mux_vec(0, 12), 64'({2'b00, {8{2'b10}}, 2'b01, 2'b01, 2'b01}));
    check("ign_ser", ser_vec(1, 8), 64'(8'h00));
    check("ign_busy", 64'(busy_count(0, 12)), 64'(10));
    check("ign_idle", 64'(cap_busy[11]), 64'(1'b0));
    check("ign_par", 64'(cap_par[11]), 64'(1'b0));

    // Reset during the 4th DATA cycle, then a clean 0x55 frame
    pulse(8'h96, 1'b1, 1'b0);
    repeat (4) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("abort_mux", 64'(Mux_Sel), 64'(2'b01));
    check("abort_busy", 64'(Busy), 64'(1'b0));
    check("abort_ser", 64'(Ser_Data), 64'(1'b0));
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    pulse(8'h55, 1'b1, 1'b0);
    capture(13);
    check("55_mux", mux_vec(0, 12), 64'({2'b00, {8{2'b10}}, 2'b11, 2'b01, 2'b01}));
    check("55_ser", ser_vec(1, 8), 64'(8'b10101010));
    check("55_par", 64'(cap_par[1]), 64'(1'b0));
    check("55_busy", 64'(busy_count(0, 13)), 64'(11));

    // Random traffic with occasional single-cycle resets
    for (int k = 0; k < 800; k++) begin
      @(posedge CLK);
      #2;
      drive(($urandom_range(0, 3) == 0), DW'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      RST = ($urandom_range(0, 149) == 0);
    end
    @(posedge CLK);
    #2;
    RST = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (20) @(posedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
Frame sequencer for the UART transmitter. It accepts a parallel byte, then steps through the start, data, optional parity and stop phases one bit per CLK. Per bit it drives the 2-bit select of the downstream 4:1 TX output mux, plus the serialized data bit and parity bit that feed two of that mux's inputs. CLK is the TX bit-rate clock, produced by the clock divider.

Parameters:
DATA_WIDTH, 8, number of payload bits per frame (legal 5..9)

Ports:
CLK  input  1  TX bit clock
RST  input  1  asynchronous, active-high reset
P_DATA  input  DATA_WIDTH  parallel payload; sampled only on accept
Data_Valid  input  1  payload request; accepted when the block is ready (see Behaviour)
PAR_EN  input  1  1 = insert a parity bit; sampled on accept
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on accept
Mux_Sel  output  2  select for the TX mux: 00 start(0), 01 stop/idle(1), 10 Ser_Data, 11 Par_Bit
Ser_Data  output  1  current payload bit, LSB first
Par_Bit  output  1  parity of the latched payload
Busy  output  1  high while a frame is in flight

Behaviour:
- Reset (async assert, any state): state=IDLE, Mux_Sel=01, Busy=0, Ser_Data=0, Par_Bit=0, bit counter=0, shift register=0.
- All outputs come from registers or from registered state only. There is no combinational path from any input to any output.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept condition: Data_Valid=1 while state is IDLE or STOP.
  - On the accept edge, latch P_DATA into the shift register, latch PAR_EN.
  - On the same edge, compute Par_Bit = (^P_DATA) XOR PAR_TYP and register it.
- IDLE: Mux_Sel=01, Busy=0. On accept, go to START.
- START: Mux_Sel=00, Busy=1. Lasts 1 cycle, then go to DATA. Ser_Data = bit0 is already valid here.
- DATA: Mux_Sel=10, lasts exactly DATA_WIDTH cycles.
  - Ser_Data = shift[0] in the first DATA cycle.
  - Each cycle, shift right and increment the counter.
  - When counter = DATA_WIDTH-1, go to PARITY if the latched PAR_EN=1, else go to STOP. Reset the counter to 0.
- PARITY: Mux_Sel=11, 1 cycle, then go to STOP.
- STOP: Mux_Sel=01, Busy=1, 1 cycle.
  - On accept, go to START: back-to-back frame, Busy stays 1 with no idle gap.
  - Otherwise go to IDLE.
- Latency: Data_Valid accepted at edge N gives start bit on line for cycle N+1. Frame length = 2 + DATA_WIDTH + PAR_EN cycles.
- Data_Valid in START/DATA/PARITY is ignored; no queuing.
- Changes on P_DATA/PAR_EN/PAR_TYP after accept do not affect the frame in flight.
- Par_Bit and Ser_Data hold their last values in IDLE. They are don't-care to the line because Mux_Sel=01 there.
- A reset mid-frame aborts immediately. The line returns to idle-high (Mux_Sel=01) asynchronously. The first accept after reset release starts a clean frame.

Decomposition:
- Package uart_tx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - Mux_Sel encodings MUX_START=2'b00, MUX_STOP=2'b01, MUX_DATA=2'b10, MUX_PAR=2'b11;
  - PAR_EVEN=0, PAR_ODD=1.
- One sub-module, uart_tx_parity_calc. It takes data and type and gives the parity bit combinationally; the parent registers the result.
- Serializer and FSM stay in the parent.

Test Plan:
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, 1-cycle Data_Valid pulse → Mux_Sel sequence 00, 10×8, 11, 01. Ser_Data over DATA = 1,0,1,0,0,1,0,1. Par_Bit=0. Busy high for 11 cycles.
- Same as above with PAR_TYP=1 → Par_Bit=1; everything else identical.
- P_DATA=0x01, PAR_EN=0 → no 11 phase, 10-cycle frame, Ser_Data = 1,0,0,0,0,0,0,0.
- Data_Valid held high with P_DATA=0x3C, then 0xC3 presented during the STOP cycle → second START immediately after STOP, Busy never drops. Second payload serializes as 1,1,0,0,0,0,1,1. Even parity = 0 for both frames.
- Data_Valid pulsed with 0xFF during DATA of a 0x00 frame → ignored. Frame 0x00 completes unchanged and the block returns to IDLE.
- RST asserted in the 4th DATA cycle → same cycle: Mux_Sel=01, Busy=0. After release, 0x55 with even parity transmits correctly, Par_Bit=0.
